alu_writeback_sequencer: RTL and testbench
==========================================

# alu_writeback_sequencer

Writeback stage directly downstream of the 16-bit ALU. It accepts one ALU result bundle per handshake and drives the single register-file write port. Multiply and divide produce two results, so it sequences them as two consecutive writes. It suppresses the write and raises a held exception when the ALU reports overflow or divide-by-zero, back-pressuring the pipeline through `in_ready` while busy.

## Interface
Parameters:
- `DATA_W`, 16, result width
- `REG_AW`, 4, register address width
- `HI_REG`, 15, destination of the second result (product high half / remainder)

Ports (name, direction, width, meaning):
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous and active-high
- `in_valid` in 1: result bundle valid
- `in_ready` out 1: stage can accept; low means stall upstream
- `in_op` in 4: opcode of the instruction
- `in_func` in 4: function code of the instruction
- `in_rd` in REG_AW: destination register
- `in_wen` in 1: instruction writes `in_rd`
- `in_res1` in DATA_W: primary result (sum, product low half, quotient, …)
- `in_res2` in DATA_W: secondary result (product high half, remainder)
- `in_ovf` in 1: ALU overflow flag
- `in_dbz` in 1: ALU divide-by-zero flag
- `rf_we` out 1: register-file write enable
- `rf_waddr` out REG_AW: write address
- `rf_wdata` out DATA_W: write data
- `exc_valid` out 1: exception pending
- `exc_cause` out 2: 00 none, 01 overflow, 10 divide-by-zero
- `exc_ack` in 1: exception handler acknowledge
- `wb_count` out 16: count of register writes performed

## Operation
- FSM with three states: RUN, WR_HI, EXC. Reset state is RUN.
- `in_ready` = (state == RUN). Accept occurs when `in_valid && in_ready`.
- On accept in RUN, the first matching rule applies:
  - `in_dbz`: no write; go to EXC with cause 10.
  - else `in_ovf`: no write; go to EXC with cause 01.
  - else `in_op==0 && in_func∈{4,5}`: write `in_rd` ← `in_res1`; latch `in_res2`; go to WR_HI.
  - else `in_wen`: write `in_rd` ← `in_res1`; stay in RUN.
  - else: no write; stay in RUN.
- WR_HI: write `HI_REG` ← latched res2, then return to RUN. If `in_rd == HI_REG`, both writes still occur and the high result wins.
- EXC: `exc_valid`=1, `exc_cause` held. On `exc_ack`, clear `exc_valid`/`exc_cause` to 0 and return to RUN.
- `exc_ack` outside EXC is ignored.
- `wb_count` increments on every cycle with `rf_we`=1 and wraps from 0xFFFF to 0.
- A dual-result op increments `wb_count` by 2 in total.

## Timing
- All outputs except `in_ready` are registered. A write appears on `rf_*` in the cycle after accept.
- The high write of a dual-result op appears 2 cycles after accept. `in_ready` is low for exactly 1 cycle (WR_HI).
- Exception: `exc_valid` rises the cycle after accept and stays high until the edge on which `exc_ack` is sampled. `in_ready` returns high the cycle after that edge.
- Back-to-back single writes are sustained at 1 per cycle.
- `rf_we` is a one-cycle pulse per write.
- Reset (async, any state) sets:
  - state to RUN
  - `rf_we`, `rf_waddr`, `rf_wdata` to 0
  - `exc_valid`, `exc_cause` to 0
  - `wb_count` to 0 and the latched res2 to 0
- A pending WR_HI write or pending exception is discarded by reset. `in_valid` is not sampled while `rst` is high.

## Structure
- Shared package holds:
  - opcode/function constants: `OP_RTYPE`=0, `FN_MUL`=4, `FN_DIV`=5
  - cause codes `EXC_NONE`/`EXC_OVF`/`EXC_DBZ`
  - the 3-state FSM enum
- Single module with no sub-module. The FSM and counter are small enough to live inline.

## Test plan
- Add, rd=3, res1=0x0012, wen=1 → next cycle `rf_we`=1, addr=3, data=0x0012; `wb_count`=1; `in_ready` stays 1.
- Mul (op 0, func 4), rd=2, res1=0x5678, res2=0x1234:
  - cycle+1: write R2=0x5678
  - cycle+2: write R15=0x1234
  - `in_ready` low during cycle+1; `wb_count` +2
- Div with `in_dbz`=1 → no `rf_we`. `exc_valid`=1, cause=10 until `exc_ack`; `in_ready` 0 throughout. Ack → cause 00, `in_ready` 1 the following cycle.
- Add with `in_ovf`=1, rd=5 → no write to R5; cause=01. Hold `exc_ack` low for 10 cycles → `exc_valid` stays high for all of them.
- Preload `wb_count`=0xFFFF via 65535 writes, then one more write → `wb_count`=0x0000.
- Assert `rst` during WR_HI of a div → R15 is never written. All outputs are 0 immediately, and `in_ready`=1 after reset is released.

Source files
------------

// File: rtl/alu_writeback_sequencer_pkg.sv
// Shared constants and FSM encoding for the ALU writeback sequencer.
// Opcode/function values mirror the ALU decode so dual-result ops are recognised identically.
package alu_writeback_sequencer_pkg;

  localparam logic [3:0] OP_RTYPE = 4'd0;
  localparam logic [3:0] FN_MUL   = 4'd4;
  localparam logic [3:0] FN_DIV   = 4'd5;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_DBZ  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WR_HI = 2'd1,
    ST_EXC   = 2'd2
  } wb_state_e;

  // Multiply and divide return a second result that needs its own write slot.
  function automatic logic is_dual_result(input logic [3:0] op, input logic [3:0] func);
    return (op == OP_RTYPE) && ((func == FN_MUL) || (func == FN_DIV));
  endfunction

endpackage

// File: rtl/alu_writeback_sequencer.sv
// Writeback stage: turns ALU result bundles into register-file writes, splits
// dual-result ops into two writes and holds ALU exceptions until acknowledged.
module alu_writeback_sequencer
  import alu_writeback_sequencer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int HI_REG = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_func,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_res1,
  input  logic [DATA_W-1:0] in_res2,
  input  logic              in_ovf,
  input  logic              in_dbz,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  input  logic              exc_ack,
  output logic [15:0]       wb_count
);

  localparam logic [REG_AW-1:0] HI_ADDR = REG_AW'(HI_REG);

  wb_state_e         state_r;
  wb_state_e         next_state_s;
  logic [DATA_W-1:0] res2_r;
  logic [DATA_W-1:0] res2_s;
  logic              we_s;
  logic [REG_AW-1:0] waddr_s;
  logic [DATA_W-1:0] wdata_s;
  logic              exc_valid_s;
  logic [1:0]        exc_cause_s;
  logic              accept_s;

  assign in_ready = (state_r == ST_RUN);
  assign accept_s = in_valid && in_ready;

  // Next-state and next-output decode; address/data hold their last value when idle.
  always_comb begin
    next_state_s = state_r;
    res2_s       = res2_r;
    we_s         = 1'b0;
    waddr_s      = rf_waddr;
    wdata_s      = rf_wdata;
    exc_valid_s  = exc_valid;
    exc_cause_s  = exc_cause;
    case (state_r)
      ST_RUN: begin
        if (!accept_s) begin
          next_state_s = ST_RUN;
        end else if (in_dbz) begin
          exc_valid_s  = 1'b1;
          exc_cause_s  = EXC_DBZ;
          next_state_s = ST_EXC;
        end else if (in_ovf) begin
          exc_valid_s  = 1'b1;
          exc_cause_s  = EXC_OVF;
          next_state_s = ST_EXC;
        end else if (is_dual_result(in_op, in_func)) begin
          we_s         = 1'b1;
          waddr_s      = in_rd;
          wdata_s      = in_res1;
          res2_s       = in_res2;
          next_state_s = ST_WR_HI;
        end else if (in_wen) begin
          we_s         = 1'b1;
          waddr_s      = in_rd;
          wdata_s      = in_res1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_WR_HI: begin
        we_s         = 1'b1;
        waddr_s      = HI_ADDR;
        wdata_s      = res2_r;
        next_state_s = ST_RUN;
      end
      ST_EXC: begin
        if (exc_ack) begin
          exc_valid_s  = 1'b0;
          exc_cause_s  = EXC_NONE;
          next_state_s = ST_RUN;
        end else begin
          exc_valid_s  = 1'b1;
        end
      end
      default: begin
        exc_valid_s  = 1'b0;
        exc_cause_s  = EXC_NONE;
        next_state_s = ST_RUN;
      end
    endcase
  end

  // State, latched high result and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_RUN;
      res2_r    <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      exc_valid <= 1'b0;
      exc_cause <= EXC_NONE;
      wb_count  <= 16'd0;
    end else begin
      state_r   <= next_state_s;
      res2_r    <= res2_s;
      rf_we     <= we_s;
      rf_waddr  <= waddr_s;
      rf_wdata  <= wdata_s;
      exc_valid <= exc_valid_s;
      exc_cause <= exc_cause_s;
      wb_count  <= we_s ? (wb_count + 16'd1) : wb_count;
    end
  end

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// Scoreboard bench: expected writes are queued at stimulus time and checked as rf_we pulses appear.
module tb_alu_writeback_sequencer;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic [3:0]  in_func = 4'd0;
  logic [3:0]  in_rd = 4'd0;
  logic        in_wen = 1'b0;
  logic [15:0] in_res1 = 16'd0;
  logic [15:0] in_res2 = 16'd0;
  logic        in_ovf = 1'b0;
  logic        in_dbz = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        exc_valid;
  logic [1:0]  exc_cause;
  logic        exc_ack = 1'b0;
  logic [15:0] wb_count;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];
  logic [15:0] cnt_model = 16'd0;

  alu_writeback_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_func(in_func), .in_rd(in_rd), .in_wen(in_wen),
    .in_res1(in_res1), .in_res2(in_res2), .in_ovf(in_ovf), .in_dbz(in_dbz),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_ack(exc_ack),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        cnt_model = cnt_model + 16'd1;
        if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
          failures++;
          $display("FAIL write_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                   rf_waddr, rf_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic set_bundle(input logic [3:0] op, input logic [3:0] func, input logic [3:0] rd,
                            input logic wen, input logic [15:0] r1, input logic [15:0] r2,
                            input logic ovf, input logic dbz);
    in_valid = 1'b1; in_op = op; in_func = func; in_rd = rd; in_wen = wen;
    in_res1 = r1; in_res2 = r2; in_ovf = ovf; in_dbz = dbz;
  endtask

  task automatic go_idle();
    in_valid = 1'b0; in_ovf = 1'b0; in_dbz = 1'b0; in_wen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause, wb_count} !== 39'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b addr=%0d data=%h exc=%b cause=%b cnt=%h, expected all 0",
               rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause, wb_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    set_bundle(4'd0, 4'd0, 4'd3, 1'b1, 16'h0012, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{addr: 4'd3, data: 16'h0012});
    @(negedge clk);
    go_idle();
    checks++;
    if (rf_we !== 1'b1 || wb_count !== 16'd1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_write: got we=%b cnt=%0d ready=%b, expected we=1 cnt=1 ready=1",
               rf_we, wb_count, in_ready);
    end
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL add_pulse: got we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_dual(input logic [3:0] func, input logic [3:0] rd,
                           input logic [15:0] lo, input logic [15:0] hi);
    logic [15:0] base;
    base = cnt_model;
    set_bundle(4'd0, func, rd, 1'b1, lo, hi, 1'b0, 1'b0);
    exp_q.push_back('{addr: rd, data: lo});
    exp_q.push_back('{addr: 4'd15, data: hi});
    @(negedge clk);
    go_idle();
    checks++;
    if (in_ready !== 1'b0 || wb_count !== base + 16'd1) begin
      failures++;
      $display("FAIL dual_first: got ready=%b cnt=%0d, expected ready=0 cnt=%0d",
               in_ready, wb_count, base + 16'd1);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || wb_count !== base + 16'd2) begin
      failures++;
      $display("FAIL dual_second: got ready=%b cnt=%0d, expected ready=1 cnt=%0d",
               in_ready, wb_count, base + 16'd2);
    end
    @(negedge clk);
  endtask

  task automatic test_exception(input logic ovf, input logic dbz, input logic [1:0] cause,
                                input int hold);
    if (dbz) set_bundle(4'd0, 4'd5, 4'd6, 1'b1, 16'h1111, 16'h2222, ovf, dbz);
    else     set_bundle(4'd1, 4'd0, 4'd5, 1'b1, 16'h7FFF, 16'h0000, ovf, dbz);
    @(negedge clk);
    // Keep offering a writable bundle: it must be ignored while the exception is held.
    set_bundle(4'd0, 4'd0, 4'd7, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (exc_valid !== 1'b1 || exc_cause !== cause || in_ready !== 1'b0 || rf_we !== 1'b0) begin
        failures++;
        $display("FAIL exc_hold[%0d]: got valid=%b cause=%b ready=%b we=%b, expected 1 %b 0 0",
                 i, exc_valid, exc_cause, in_ready, rf_we, cause);
      end
      @(negedge clk);
    end
    go_idle();
    exc_ack = 1'b1;
    @(negedge clk);
    exc_ack = 1'b0;
    checks++;
    if (exc_valid !== 1'b0 || exc_cause !== 2'b00 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL exc_ack: got valid=%b cause=%b ready=%b, expected 0 00 1",
               exc_valid, exc_cause, in_ready);
    end
  endtask

  task automatic test_ack_outside();
    exc_ack = 1'b1;
    set_bundle(4'd2, 4'd1, 4'd9, 1'b1, 16'hA5A5, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{addr: 4'd9, data: 16'hA5A5});
    @(negedge clk);
    go_idle();
    exc_ack = 1'b0;
    checks++;
    if (exc_valid !== 1'b0 || exc_cause !== 2'b00 || rf_we !== 1'b1) begin
      failures++;
      $display("FAIL ack_outside: got valid=%b cause=%b we=%b, expected 0 00 1",
               exc_valid, exc_cause, rf_we);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] base;
    base = cnt_model;
    for (int i = 0; i < 5; i++) begin
      set_bundle(4'd1, 4'd0, 4'(i + 1), (i != 2), 16'(16'h0100 + i), 16'h0000, 1'b0, 1'b0);
      if (i != 2) exp_q.push_back('{addr: 4'(i + 1), data: 16'(16'h0100 + i)});
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got %b expected 1", i, in_ready);
      end
    end
    go_idle();
    @(negedge clk);
    checks++;
    if (wb_count !== base + 16'd4) begin
      failures++;
      $display("FAIL b2b_count: got %0d expected %0d", wb_count, base + 16'd4);
    end
  endtask

  task automatic test_wrap();
    int n;
    n = 32'hFFFF - int'(cnt_model);
    set_bundle(4'd1, 4'd0, 4'd4, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      in_res1 = 16'(i);
      exp_q.push_back('{addr: 4'd4, data: 16'(i)});
      @(negedge clk);
    end
    go_idle();
    @(negedge clk);
    checks++;
    if (wb_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL wrap_pre: got %h expected ffff", wb_count);
    end
    set_bundle(4'd1, 4'd0, 4'd4, 1'b1, 16'hCAFE, 16'h0000, 1'b0, 1'b0);
    exp_q.push_back('{addr: 4'd4, data: 16'hCAFE});
    @(negedge clk);
    go_idle();
    checks++;
    if (wb_count !== 16'h0000) begin
      failures++;
      $display("FAIL wrap_zero: got %h expected 0000", wb_count);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_in_wrhi();
    set_bundle(4'd0, 4'd5, 4'd1, 1'b1, 16'h0042, 16'h0099, 1'b0, 1'b0);
    exp_q.push_back('{addr: 4'd1, data: 16'h0042});
    @(negedge clk);
    go_idle();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause, wb_count} !== 39'd0) begin
      failures++;
      $display("FAIL rst_async: got we=%b addr=%0d data=%h exc=%b cause=%b cnt=%h, expected all 0",
               rf_we, rf_waddr, rf_wdata, exc_valid, exc_cause, wb_count);
    end
    cnt_model = 16'd0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready: got %b expected 1", in_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wb_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_no_hi: got cnt=%0d expected 0", wb_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_dual(4'd4, 4'd2, 16'h5678, 16'h1234);
    test_exception(1'b0, 1'b1, 2'b10, 3);
    test_exception(1'b1, 1'b0, 2'b01, 10);
    test_ack_outside();
    test_back_to_back();
    test_dual(4'd5, 4'd15, 16'h0003, 16'h0004);
    test_wrap();
    test_reset_in_wrhi();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_writes: got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
